infoframe_scheduler: RTL and testbench

INFOFRAME_SCHEDULER -- requirements
Module: infoframe_scheduler

---
 rtl/infoframe_scheduler.sv | 136 +++++++++++++
 tb/tb_infoframe_scheduler.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/infoframe_scheduler.sv
// Data-island packet scheduler: picks ACR, audio sample, a round-robin InfoFrame or a
// null packet for each slot, and tracks per-frame InfoFrame delivery.
module infoframe_scheduler #(
  parameter int unsigned IF_GAP = 2
) (
  input  logic       clk_pixel,
  input  logic       reset,
  input  logic       frame_start,
  input  logic       slot_ready,
  input  logic       acr_req,
  input  logic       audio_req,
  input  logic [3:0] if_enable,
  output logic [7:0] packet_type,
  output logic       packet_valid,
  output logic       acr_ack,
  output logic       audio_ack,
  output logic       frame_done,
  output logic       missed
);

  localparam int unsigned NUM_IF = 4;
  localparam int unsigned GAP_W  = 4;
  localparam int unsigned TYPE_W = 8;

  localparam logic [TYPE_W-1:0] TYPE_NULL  = 8'h00;
  localparam logic [TYPE_W-1:0] TYPE_ACR   = 8'h01;
  localparam logic [TYPE_W-1:0] TYPE_AUDIO = 8'h02;
  localparam logic [TYPE_W-1:0] TYPE_AVI   = 8'h82;
  localparam logic [TYPE_W-1:0] TYPE_AIF   = 8'h84;
  localparam logic [TYPE_W-1:0] TYPE_SPD   = 8'h83;
  localparam logic [TYPE_W-1:0] TYPE_VSIF  = 8'h81;

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    ACTIVE     = 2'd1,
    DONE       = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [NUM_IF-1:0]   pending, pending_after, pending_nxt, grant_mask, eligible;
  logic [1:0]          rr_ptr, rr_nxt, if_sel;
  logic                if_sel_valid;
  logic [GAP_W-1:0]    gap, gap_nxt;
  logic                take_acr, take_audio, take_if;
  logic [TYPE_W-1:0]   type_nxt;
  logic                frame_done_nxt;

  // Round-robin search over eligible InfoFrames starting at rr_ptr.
  always_comb begin
    logic [1:0] idx;
    if_sel_valid = 1'b0;
    if_sel       = 2'd0;
    idx          = 2'd0;
    eligible     = pending & {NUM_IF{(gap == '0) && (state != WAIT_FRAME)}};
    for (int k = 0; k < NUM_IF; k++) begin
      idx = rr_ptr + 2'(k);
      if (!if_sel_valid && eligible[idx]) begin
        if_sel_valid = 1'b1;
        if_sel       = idx;
      end
    end
  end

  always_comb begin
    take_acr      = slot_ready & acr_req;
    take_audio    = slot_ready & ~acr_req & audio_req;
    take_if       = slot_ready & ~acr_req & ~audio_req & if_sel_valid;
    grant_mask    = take_if ? (NUM_IF'(1) << if_sel) : '0;
    pending_after = pending & ~grant_mask;
    pending_nxt   = frame_start ? if_enable : pending_after;
    rr_nxt        = take_if ? 2'(if_sel + 2'd1) : rr_ptr;

    if (take_if)                      gap_nxt = GAP_W'(IF_GAP);
    else if (slot_ready && gap != '0) gap_nxt = gap - GAP_W'(1);
    else                              gap_nxt = gap;

    type_nxt = TYPE_NULL;
    if (take_acr)        type_nxt = TYPE_ACR;
    else if (take_audio) type_nxt = TYPE_AUDIO;
    else if (take_if) begin
      case (if_sel)
        2'd0:    type_nxt = TYPE_AVI;
        2'd1:    type_nxt = TYPE_AIF;
        2'd2:    type_nxt = TYPE_SPD;
        default: type_nxt = TYPE_VSIF;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk_pixel) begin
    if (reset) state <= WAIT_FRAME;
    else       state <= state_nxt;
  end

  // Next-state: frame_start always re-arms; ACTIVE retires once nothing is left pending.
  always_comb begin
    state_nxt = state;
    if (frame_start)
      state_nxt = (if_enable != '0) ? ACTIVE : DONE;
    else if (state == ACTIVE && pending_after == '0)
      state_nxt = DONE;
  end

  // Output decode, registered below alongside the other outputs
  always_comb begin
    frame_done_nxt = 1'b0;
    if (state_nxt == DONE) frame_done_nxt = 1'b1;
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      packet_type  <= TYPE_NULL;
      packet_valid <= 1'b0;
      acr_ack      <= 1'b0;
      audio_ack    <= 1'b0;
      frame_done   <= 1'b0;
      missed       <= 1'b0;
      pending      <= '0;
      rr_ptr       <= '0;
      gap          <= '0;
    end else begin
      packet_valid <= slot_ready;
      acr_ack      <= take_acr;
      audio_ack    <= take_audio;
      if (slot_ready) packet_type <= type_nxt;
      frame_done   <= frame_done_nxt;
      // An InfoFrame granted in the same cycle as frame_start counts as sent.
      missed       <= missed | (frame_start & (|pending_after));
      pending      <= pending_nxt;
      rr_ptr       <= rr_nxt;
      gap          <= gap_nxt;
    end
  end

endmodule

// File: tb/tb_infoframe_scheduler.sv
// Directed bench for infoframe_scheduler: one instance with IF_GAP=0, one with IF_GAP=2,
// sharing inputs; each step checks the instance it targets.
module tb_infoframe_scheduler;

  logic       clk_pixel = 1'b0;
  logic       reset, frame_start, slot_ready, acr_req, audio_req;
  logic [3:0] if_enable;

  logic [7:0] p0_type, p2_type;
  logic       p0_valid, p0_acr, p0_aud, p0_done, p0_missed;
  logic       p2_valid, p2_acr, p2_aud, p2_done, p2_missed;

  int tests = 0;
  int fails = 0;

  always #5 clk_pixel = ~clk_pixel;

  infoframe_scheduler #(.IF_GAP(0)) dut0 (
    .clk_pixel(clk_pixel), .reset(reset), .frame_start(frame_start),
    .slot_ready(slot_ready), .acr_req(acr_req), .audio_req(audio_req),
    .if_enable(if_enable), .packet_type(p0_type), .packet_valid(p0_valid),
    .acr_ack(p0_acr), .audio_ack(p0_aud), .frame_done(p0_done), .missed(p0_missed)
  );

  infoframe_scheduler #(.IF_GAP(2)) dut2 (
    .clk_pixel(clk_pixel), .reset(reset), .frame_start(frame_start),
    .slot_ready(slot_ready), .acr_req(acr_req), .audio_req(audio_req),
    .if_enable(if_enable), .packet_type(p2_type), .packet_valid(p2_valid),
    .acr_ack(p2_acr), .audio_ack(p2_aud), .frame_done(p2_done), .missed(p2_missed)
  );

  task automatic tick();
    @(posedge clk_pixel);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; frame_start = 1'b0; slot_ready = 1'b0;
    acr_req = 1'b0; audio_req = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic new_frame(input logic [3:0] en);
    if_enable = en; frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  // Pulse slot_ready for one cycle; outputs are sampled just after the sampling edge.
  task automatic slot();
    slot_ready = 1'b1;
    tick();
    slot_ready = 1'b0;
  endtask

  logic [7:0] exp4 [4];
  logic [7:0] exp5 [5];

  initial begin
    if_enable = 4'b0000;
    do_reset();

    // Reset values
    chk("rst_type",   p0_type,   8'h00);
    chk("rst_valid",  {7'd0, p0_valid},  8'h00);
    chk("rst_done",   {7'd0, p0_done},   8'h00);
    chk("rst_missed", {7'd0, p0_missed}, 8'h00);

    // Before the first frame only null is available
    if_enable = 4'b1111;
    slot();
    chk("wait_valid", {7'd0, p0_valid}, 8'h01);
    chk("wait_type",  p0_type, 8'h00);
    chk("wait_done",  {7'd0, p0_done}, 8'h00);

    // All four InfoFrames in round-robin order with no gap
    new_frame(4'b1111);
    chk("rr_active", {7'd0, p0_done}, 8'h00);
    exp4[0] = 8'h82; exp4[1] = 8'h84; exp4[2] = 8'h83; exp4[3] = 8'h81;
    for (int i = 0; i < 4; i++) begin
      slot();
      chk($sformatf("rr_valid%0d", i), {7'd0, p0_valid}, 8'h01);
      chk($sformatf("rr_type%0d", i),  p0_type, exp4[i]);
      chk($sformatf("rr_done%0d", i),  {7'd0, p0_done}, (i == 3) ? 8'h01 : 8'h00);
      tick();
      chk($sformatf("rr_idle%0d", i),  {7'd0, p0_valid}, 8'h00);
      chk($sformatf("rr_hold%0d", i),  p0_type, exp4[i]);
    end

    // Gap of 2 between InfoFrame grants
    do_reset();
    new_frame(4'b0101);
    exp5[0] = 8'h82; exp5[1] = 8'h00; exp5[2] = 8'h00; exp5[3] = 8'h83; exp5[4] = 8'h00;
    for (int i = 0; i < 5; i++) begin
      slot();
      chk($sformatf("gap_type%0d", i), p2_type, exp5[i]);
      chk($sformatf("gap_valid%0d", i), {7'd0, p2_valid}, 8'h01);
      tick();
    end
    chk("gap_done", {7'd0, p2_done}, 8'h01);

    // ACR beats audio beats InfoFrame; AVI survives until it wins a slot
    do_reset();
    new_frame(4'b0001);
    acr_req = 1'b1; audio_req = 1'b1;
    slot();
    chk("pri_acr_type", p0_type, 8'h01);
    chk("pri_acr_ack",  {6'd0, p0_acr, p0_aud}, 8'h02);
    acr_req = 1'b0;
    slot();
    chk("pri_aud_type", p0_type, 8'h02);
    chk("pri_aud_ack",  {6'd0, p0_acr, p0_aud}, 8'h01);
    chk("pri_not_done", {7'd0, p0_done}, 8'h00);
    audio_req = 1'b0;
    slot();
    chk("pri_avi_type", p0_type, 8'h82);
    chk("pri_avi_ack",  {6'd0, p0_acr, p0_aud}, 8'h00);
    chk("pri_avi_done", {7'd0, p0_done}, 8'h01);

    // Unsent VSIF at the next frame_start sets sticky missed
    do_reset();
    new_frame(4'b1000);
    chk("miss_pre", {7'd0, p0_missed}, 8'h00);
    new_frame(4'b1000);
    chk("miss_set",    {7'd0, p0_missed}, 8'h01);
    chk("miss_active", {7'd0, p0_done},   8'h00);
    slot();
    chk("miss_vsif",   p0_type, 8'h81);
    chk("miss_done",   {7'd0, p0_done},   8'h01);
    new_frame(4'b0000);
    chk("miss_sticky", {7'd0, p0_missed}, 8'h01);
    chk("miss_empty_done", {7'd0, p0_done}, 8'h01);
    do_reset();
    chk("miss_clear",  {7'd0, p0_missed}, 8'h00);

    // frame_start coincident with an SPD grant reloads SPD
    new_frame(4'b0100);
    frame_start = 1'b1; slot_ready = 1'b1;
    tick();
    frame_start = 1'b0; slot_ready = 1'b0;
    chk("coin_type",   p0_type, 8'h83);
    chk("coin_valid",  {7'd0, p0_valid}, 8'h01);
    chk("coin_active", {7'd0, p0_done},  8'h00);
    slot();
    chk("coin_again",  p0_type, 8'h83);
    chk("coin_done",   {7'd0, p0_done},  8'h01);

    // if_enable changes mid-frame are ignored
    do_reset();
    new_frame(4'b0001);
    if_enable = 4'b1111;
    slot();
    chk("en_avi",  p0_type, 8'h82);
    slot();
    chk("en_null", p0_type, 8'h00);
    chk("en_done", {7'd0, p0_done}, 8'h01);

    // Reset on the edge that samples slot_ready suppresses the strobe and clears pending
    do_reset();
    new_frame(4'b0010);
    slot();
    chk("rs_pre_type", p0_type, 8'h84);
    new_frame(4'b0010);
    reset = 1'b1; slot_ready = 1'b1;
    tick();
    reset = 1'b0; slot_ready = 1'b0;
    chk("rs_valid", {7'd0, p0_valid}, 8'h00);
    chk("rs_type",  p0_type, 8'h00);
    chk("rs_done",  {7'd0, p0_done}, 8'h00);
    chk("rs_acks",  {6'd0, p0_acr, p0_aud}, 8'h00);
    slot();
    chk("rs_discard", p0_type, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
